// File: rtl/req_pkg.sv
// Shared constants and helpers for the request dispatcher and related arbiters.
package req_pkg;

  localparam logic MODE_BROADCAST   = 1'b0;
  localparam logic MODE_ROUND_ROBIN = 1'b1;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Add 0..3 to a counter, clamping at max instead of wrapping.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [1:0]  inc,
                                          input logic [63:0] max);
    if ((max - a) < 64'(inc)) return max;
    return a + 64'(inc);
  endfunction

endpackage

// File: rtl/req_dispatcher_if.sv
// Request-ID stream in plus per-channel dispatch strobes out.
interface req_dispatcher_if #(
  parameter int unsigned REQ_ID_WIDTH = 32,
  parameter int unsigned NUM_CH       = 2
);
  logic [REQ_ID_WIDTH-1:0] FIFO_TDATA;
  logic                    FIFO_TVALID;
  logic                    FIFO_TREADY;
  logic [NUM_CH-1:0]       ch_ready;
  logic [NUM_CH-1:0]       req_id_valid;
  logic [REQ_ID_WIDTH-1:0] req_id;

  modport master (
    input  FIFO_TDATA, FIFO_TVALID, ch_ready,
    output FIFO_TREADY, req_id_valid, req_id
  );

  modport slave (
    output FIFO_TDATA, FIFO_TVALID, ch_ready,
    input  FIFO_TREADY, req_id_valid, req_id
  );
endinterface

// File: rtl/req_dispatcher_rr_select.sv
// Rotating-priority finder: first ready index at or after ptr, wrapping modulo NUM_CH.
module rr_select #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] ready,
  input  logic [PTR_W-1:0]  ptr,
  output logic [PTR_W-1:0]  sel,
  output logic              any_ready
);

  logic [NUM_CH-1:0] rotated;
  int unsigned       idx;

  always_comb begin
    // Rotate so bit 0 is the channel at ptr; lowest set bit is then the winner.
    rotated = NUM_CH'({ready, ready} >> ptr);
    idx     = 32'(ptr);
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (rotated[i-1]) idx = 32'(ptr) + i - 1;
    end
    if (idx >= NUM_CH) idx = idx - NUM_CH;
    sel       = PTR_W'(idx);
    any_ready = |ready;
  end

endmodule

// File: rtl/req_dispatcher.sv
// Single-entry request-ID stage dispatched to NUM_CH consumers, broadcast or round-robin.
module req_dispatcher
  import req_pkg::*;
#(
  parameter int unsigned REQ_ID_WIDTH = 32,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ignore_rx,
  input  logic                 mode,
  req_dispatcher_if.master     bus,
  output logic [CNT_WIDTH-1:0] presented_count,
  output logic [CNT_WIDTH-1:0] dropped_count,
  output logic                 busy
);

  localparam int unsigned       PTR_W    = clog2(NUM_CH);
  localparam logic [63:0]       CNT_MAX  = 64'({CNT_WIDTH{1'b1}});
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  logic                    full;
  logic [REQ_ID_WIDTH-1:0] stage;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        sel;
  logic [PTR_W-1:0]        next_ptr;
  logic                    any_ready;
  logic                    fire;
  logic                    accept;
  logic [1:0]              drop_inc;

  rr_select #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_select (
    .ready     (bus.ch_ready),
    .ptr       (rr_ptr),
    .sel       (sel),
    .any_ready (any_ready)
  );

  always_comb begin
    fire = full & ~ignore_rx &
           ((mode == MODE_ROUND_ROBIN) ? any_ready : (&bus.ch_ready));
    // Refill through fire lets a full stage take a new beat every cycle.
    bus.FIFO_TREADY = ~reset & (ignore_rx | ~full | fire);
    accept          = bus.FIFO_TVALID & bus.FIFO_TREADY;

    bus.req_id_valid = '0;
    if (fire) begin
      bus.req_id_valid = (mode == MODE_ROUND_ROBIN) ? (ONE_HOT0 << sel) : '1;
    end

    drop_inc = ignore_rx ? ({1'b0, accept} + {1'b0, full}) : 2'b00;
    next_ptr = (sel == PTR_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
  end

  assign bus.req_id = stage;
  assign busy       = full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full  <= 1'b0;
      stage <= '0;
    end else if (ignore_rx) begin
      full <= 1'b0;
    end else if (accept) begin
      full  <= 1'b1;
      stage <= bus.FIFO_TDATA;
    end else if (fire) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (fire && (mode == MODE_ROUND_ROBIN)) begin
      rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presented_count <= '0;
      dropped_count   <= '0;
    end else begin
      presented_count <= CNT_WIDTH'(sat_add(64'(presented_count), {1'b0, fire}, CNT_MAX));
      dropped_count   <= CNT_WIDTH'(sat_add(64'(dropped_count), drop_inc, CNT_MAX));
    end
  end

endmodule

// File: tb/tb_req_dispatcher.sv
// Bench for req_dispatcher: a 2-channel/4-bit-counter instance and a 3-channel instance.
module tb_req_dispatcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit          ign_v[2];
  bit          mode_v[2];
  bit          tvalid_v[2];
  logic [31:0] tdata_v[2];
  int          ready_v[2];

  req_dispatcher_if #(.REQ_ID_WIDTH(8),  .NUM_CH(2)) if2 ();
  req_dispatcher_if #(.REQ_ID_WIDTH(32), .NUM_CH(3)) if3 ();

  assign if2.FIFO_TDATA  = tdata_v[0][7:0];
  assign if2.FIFO_TVALID = tvalid_v[0];
  assign if2.ch_ready    = ready_v[0][1:0];
  assign if3.FIFO_TDATA  = tdata_v[1];
  assign if3.FIFO_TVALID = tvalid_v[1];
  assign if3.ch_ready    = ready_v[1][2:0];

  logic [3:0]  pres2, drop2;
  logic [31:0] pres3, drop3;
  logic        busy2, busy3;

  req_dispatcher #(.REQ_ID_WIDTH(8), .NUM_CH(2), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .reset(rst), .ignore_rx(ign_v[0]), .mode(mode_v[0]), .bus(if2),
    .presented_count(pres2), .dropped_count(drop2), .busy(busy2)
  );

  req_dispatcher #(.REQ_ID_WIDTH(32), .NUM_CH(3), .CNT_WIDTH(32)) dut3 (
    .clk(clk), .reset(rst), .ignore_rx(ign_v[1]), .mode(mode_v[1]), .bus(if3),
    .presented_count(pres3), .dropped_count(drop3), .busy(busy3)
  );

  // Reference model: an optional held item, a "next channel to try" pointer, integer counters.
  int          nch[2]   = '{2, 3};
  longint      cmax[2]  = '{15, 64'd4294967295};
  logic [31:0] dmask[2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
  bit          m_has[2];
  logic [31:0] m_item[2];
  int          m_ptr[2];
  longint      m_pres[2];
  longint      m_drop[2];

  int vectors     = 0;
  int miscompares = 0;

  function automatic longint clamp(input longint x, input longint mx);
    return (x > mx) ? mx : x;
  endfunction

  function automatic void model_reset(input int d);
    m_has[d]  = 1'b0;
    m_item[d] = '0;
    m_ptr[d]  = 0;
    m_pres[d] = 0;
    m_drop[d] = 0;
  endfunction

  function automatic void model_eval(input int d, output bit tr, output int vmask,
                                     output bit fire, output int chosen);
    int all;
    int rdy;
    all    = (1 << nch[d]) - 1;
    rdy    = ready_v[d] & all;
    chosen = -1;
    for (int k = 0; k < nch[d]; k++) begin
      if (chosen < 0 && ((rdy >> ((m_ptr[d] + k) % nch[d])) & 1) == 1)
        chosen = (m_ptr[d] + k) % nch[d];
    end
    fire  = m_has[d] && !ign_v[d] && (mode_v[d] ? (rdy != 0) : (rdy == all));
    vmask = !fire ? 0 : (mode_v[d] ? (1 << chosen) : all);
    tr    = !rst && (ign_v[d] || !m_has[d] || fire);
  endfunction

  function automatic void model_advance(input int d);
    bit tr, fire, acc;
    int vm, ch;
    if (rst) begin
      model_reset(d);
      return;
    end
    model_eval(d, tr, vm, fire, ch);
    acc = tvalid_v[d] && tr;
    if (ign_v[d]) begin
      m_drop[d] = clamp(m_drop[d] + longint'(acc) + longint'(m_has[d]), cmax[d]);
      m_has[d]  = 1'b0;
    end else if (acc) begin
      m_has[d]  = 1'b1;
      m_item[d] = tdata_v[d] & dmask[d];
    end else if (fire) begin
      m_has[d] = 1'b0;
    end
    if (fire) m_pres[d] = clamp(m_pres[d] + 1, cmax[d]);
    if (fire && mode_v[d]) m_ptr[d] = (ch + 1) % nch[d];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic read_dut(input int d, output bit tr, output int v, output logic [31:0] id,
                          output longint pr, output longint dr, output bit bs);
    if (d == 0) begin
      tr = if2.FIFO_TREADY; v = 32'(if2.req_id_valid); id = 32'(if2.req_id);
      pr = 64'(pres2); dr = 64'(drop2); bs = busy2;
    end else begin
      tr = if3.FIFO_TREADY; v = 32'(if3.req_id_valid); id = if3.req_id;
      pr = 64'(pres3); dr = 64'(drop3); bs = busy3;
    end
  endtask

  task automatic check_dut(input int d);
    bit tr, fire, a_tr, a_bs;
    int vm, ch, a_v;
    logic [31:0] a_id;
    longint a_pr, a_dr;
    model_eval(d, tr, vm, fire, ch);
    read_dut(d, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk($sformatf("dut%0d.tready", d),    longint'(a_tr), longint'(tr));
    chk($sformatf("dut%0d.valid", d),     longint'(a_v),  longint'(vm));
    chk($sformatf("dut%0d.req_id", d),    longint'(a_id), longint'(m_item[d]));
    chk($sformatf("dut%0d.presented", d), a_pr,           m_pres[d]);
    chk($sformatf("dut%0d.dropped", d),   a_dr,           m_drop[d]);
    chk($sformatf("dut%0d.busy", d),      longint'(a_bs), longint'(m_has[d]));
  endtask

  // One clock: drive DUT d (the other DUT sees no beat), check both at the falling edge.
  task automatic cycle(input int d, input bit ign, input bit md, input bit tv,
                       input logic [31:0] data, input int rdy);
    @(posedge clk);
    #1;
    tvalid_v[0] = 1'b0;
    tvalid_v[1] = 1'b0;
    ign_v[d]    = ign;
    mode_v[d]   = md;
    tvalid_v[d] = tv;
    tdata_v[d]  = data;
    ready_v[d]  = rdy;
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    model_advance(0);
    model_advance(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          d;
    bit          mode;
    bit          tv;
    logic [31:0] data;
    int          rdy;
    int          exp_v;
    logic [31:0] exp_id;
    bit          exp_tr;
    int          exp_pres;
  } vec_t;

  vec_t tbl[$];

  bit          a_tr, a_bs;
  int          a_v;
  logic [31:0] a_id;
  longint      a_pr, a_dr;
  bit          mode_r[2];

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Broadcast on 2 channels, then broadcast blocked by a non-ready channel.
    tbl.push_back('{0, 0, 1, 'h10, 3, 0, 0,     1, 0});
    tbl.push_back('{0, 0, 1, 'h11, 3, 3, 'h10,  1, -1});
    tbl.push_back('{0, 0, 1, 'h12, 3, 3, 'h11,  1, -1});
    tbl.push_back('{0, 0, 0, 0,    3, 3, 'h12,  1, -1});
    tbl.push_back('{0, 0, 0, 0,    3, 0, 0,     1, 3});
    tbl.push_back('{0, 0, 1, 'h20, 1, 0, 0,     1, -1});
    tbl.push_back('{0, 0, 0, 0,    1, 0, 0,     0, -1});
    tbl.push_back('{0, 0, 0, 0,    1, 0, 0,     0, -1});
    tbl.push_back('{0, 0, 0, 0,    3, 3, 'h20,  1, -1});
    tbl.push_back('{0, 0, 0, 0,    3, 0, 0,     1, 4});
    // Round-robin on 3 channels, all ready, then only ch0/ch2 ready.
    tbl.push_back('{1, 1, 1, 'hA,  7, 0, 0,     1, 0});
    tbl.push_back('{1, 1, 1, 'hB,  7, 1, 'hA,   1, -1});
    tbl.push_back('{1, 1, 1, 'hC,  7, 2, 'hB,   1, -1});
    tbl.push_back('{1, 1, 1, 'hD,  7, 4, 'hC,   1, -1});
    tbl.push_back('{1, 1, 1, 'hE,  7, 1, 'hD,   1, -1});
    tbl.push_back('{1, 1, 1, 'hF,  7, 2, 'hE,   1, -1});
    tbl.push_back('{1, 1, 0, 0,    7, 4, 'hF,   1, -1});
    tbl.push_back('{1, 1, 0, 0,    7, 0, 0,     1, 6});
    tbl.push_back('{1, 1, 1, 'h1A, 5, 0, 0,     1, -1});
    tbl.push_back('{1, 1, 1, 'h1B, 5, 1, 'h1A,  1, -1});
    tbl.push_back('{1, 1, 1, 'h1C, 5, 4, 'h1B,  1, -1});
    tbl.push_back('{1, 1, 1, 'h1D, 5, 1, 'h1C,  1, -1});
    tbl.push_back('{1, 1, 0, 0,    5, 4, 'h1D,  1, -1});
    tbl.push_back('{1, 1, 0, 0,    5, 0, 0,     1, 10});

    for (int d = 0; d < 2; d++) begin
      ign_v[d] = 0; mode_v[d] = 0; tvalid_v[d] = 0; tdata_v[d] = '0; ready_v[d] = 0;
      model_reset(d);
    end
    #12;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].d, 1'b0, tbl[i].mode, tbl[i].tv, tbl[i].data, tbl[i].rdy);
      read_dut(tbl[i].d, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
      chk($sformatf("tbl%0d.tready", i), longint'(a_tr), longint'(tbl[i].exp_tr));
      chk($sformatf("tbl%0d.valid", i),  longint'(a_v),  longint'(tbl[i].exp_v));
      if (tbl[i].exp_v != 0)
        chk($sformatf("tbl%0d.req_id", i), longint'(a_id), longint'(tbl[i].exp_id));
      if (tbl[i].exp_pres >= 0)
        chk($sformatf("tbl%0d.presented", i), a_pr, longint'(tbl[i].exp_pres));
    end

    // Flush of a staged ID plus an incoming beat counts two drops in one cycle.
    do_reset();
    cycle(0, 0, 0, 1, 'h55, 0);
    cycle(0, 1, 0, 1, 'h56, 0);
    read_dut(0, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("ign.tready", longint'(a_tr), 1);
    chk("ign.valid",  longint'(a_v),  0);
    cycle(0, 1, 0, 1, 'h57, 0);
    read_dut(0, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("ign.drop_pair", a_dr, 2);
    chk("ign.flushed",   longint'(a_bs), 0);
    cycle(0, 1, 0, 1, 'h58, 0);
    read_dut(0, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("ign.drop_single", a_dr, 3);
    cycle(0, 0, 0, 1, 'h59, 3);
    read_dut(0, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("ign.resume_drop",  a_dr, 4);
    chk("ign.resume_empty", longint'(a_bs), 0);
    chk("ign.resume_tready", longint'(a_tr), 1);
    cycle(0, 0, 0, 0, 0, 3);
    read_dut(0, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("ign.resume_valid", longint'(a_v), 3);
    chk("ign.resume_id",    longint'(a_id), 'h59);

    // Presented counter saturates at 4'hF.
    do_reset();
    for (int i = 0; i < 21; i++) cycle(0, 0, 0, 1, 32'(i), 3);
    cycle(0, 0, 0, 0, 0, 3);
    read_dut(0, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("sat.presented", a_pr, 15);

    // A +2 drop at 14 clamps to 4'hF.
    do_reset();
    for (int i = 0; i < 14; i++) cycle(0, 1, 0, 1, 32'(i), 0);
    cycle(0, 0, 0, 1, 'h77, 0);
    read_dut(0, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("sat.drop14", a_dr, 14);
    cycle(0, 1, 0, 1, 'h78, 0);
    cycle(0, 0, 0, 0, 0, 0);
    read_dut(0, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("sat.drop_clamp", a_dr, 15);

    // Asynchronous reset mid-cycle with the stage full and rr_ptr advanced.
    cycle(1, 0, 1, 1, 'h31, 7);
    cycle(1, 0, 1, 0, 0, 7);
    cycle(1, 0, 1, 1, 'h33, 0);
    cycle(1, 0, 1, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    read_dut(1, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("areset.tready", longint'(a_tr), 0);
    chk("areset.valid",  longint'(a_v),  0);
    chk("areset.req_id", longint'(a_id), 0);
    chk("areset.pres",   a_pr, 0);
    chk("areset.busy",   longint'(a_bs), 0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, 1, 1, 'h40, 7);
    cycle(1, 0, 1, 0, 0, 7);
    read_dut(1, a_tr, a_v, a_id, a_pr, a_dr, a_bs);
    chk("areset.first_ch0", longint'(a_v), 1);
    chk("areset.first_id",  longint'(a_id), 'h40);

    // Randomized traffic against the model on both instances.
    mode_r[0] = 0;
    mode_r[1] = 1;
    for (int n = 0; n < 3000; n++) begin
      int d;
      int rdy;
      d = int'($urandom_range(1, 0));
      if ($urandom_range(19, 0) == 0) mode_r[d] = ~mode_r[d];
      rdy = ($urandom_range(1, 0) == 0) ? 7 : int'($urandom_range(7, 0));
      cycle(d, $urandom_range(9, 0) == 0, mode_r[d], $urandom_range(3, 0) != 0,
            $urandom, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
